sdram_init_ctrl: RTL and testbench
==================================

SDRAM_INIT_CTRL -- requirements
Module: sdram_init_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WAIT_CYC, 20000, power-up wait in clocks (200 us at 100 MHz); legal range 1 or more.
- T_RP, 3, precharge-to-next-command spacing in clocks; legal range 1 or more.
- T_RFC, 8, refresh-to-next-command spacing in clocks; legal range 1 or more.
- T_MRD, 2, mode-register-set to done spacing in clocks; legal range 1 or more.
- REF_NUM, 8, number of init auto-refreshes; legal range 1 or more.
- ADDR_W, 13, SDRAM address width; legal range 11 or more.
- MODE_REG, 13'h032, mode word (CAS 3, burst length 4, sequential); width ADDR_W.
- REFI_CYC, 780, periodic refresh interval in clocks.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, the single clock.
- RST, in, 1, synchronous active-high reset.
- CKE_o, out, 1, SDRAM clock enable.
- CMD_o, out, 4, {CS_n, RAS_n, CAS_n, WE_n}.
- ADDR_o, out, ADDR_W, SDRAM address.
- BA_o, out, 2, bank address.
- INIT_WAIT_200_o, out, 1, power-up wait elapsed (sticky).
- INIT_DONE_o, out, 1, init sequence complete (sticky).
- REF_REQ_o, out, 1, periodic refresh request (SDRAM_REF_TIMER_EN only).
- REF_ACK_i, in, 1, refresh request accepted (SDRAM_REF_TIMER_EN only).
- REF_OVF_o, out, 1, sticky missed-refresh flag (SDRAM_REF_TIMER_EN only).

Function
REQ-003 Command encodings SHALL be NOP 4'b0111, PRE 4'b0010, REF 4'b0001, MRS 4'b0000; every cycle not issuing a command SHALL drive NOP.
REQ-004 FSM states SHALL be WAIT, PRE, TRP, REF, TRFC, MRS, TMRD, DONE; each command state SHALL last exactly one cycle.
REQ-005 Cycle 0 is the first cycle after RST deasserts; CKE_o SHALL be 1 from cycle 0 onward.
REQ-006 WAIT SHALL last WAIT_CYC cycles; INIT_WAIT_200_o SHALL rise with the PRE command at cycle WAIT_CYC and stay 1 until reset.
REQ-007 PRE SHALL drive ADDR_o[10]=1 (all banks); the next command SHALL issue exactly T_RP cycles after PRE.
REQ-008 REF SHALL be issued REF_NUM times, each spaced T_RFC cycles from the next command; the refresh count SHALL be held in a counter of width $clog2(REF_NUM+1).
REQ-009 MRS SHALL drive ADDR_o=MODE_REG and BA_o=0; INIT_DONE_o SHALL rise exactly T_MRD cycles after MRS.
REQ-010 DONE SHALL be terminal; only RST leaves it; in DONE, CMD_o SHALL be NOP.
REQ-011 ADDR_o and BA_o SHALL be 0 in every cycle except PRE (bit 10 set) and MRS.
REQ-012 All outputs SHALL be registered; the command SHALL appear in the same cycle the FSM is in its command state.

Reset
REQ-013 RST sampled high SHALL, on the next edge, set: FSM=WAIT, all counters=0, CKE_o=0, CMD_o=NOP, ADDR_o=0, BA_o=0, INIT_WAIT_200_o=0, INIT_DONE_o=0, REF_REQ_o=0, REF_OVF_o=0.
REQ-014 RST asserted in any state, including mid-sequence, SHALL abort the sequence; the full sequence SHALL restart from WAIT after RST deasserts.

Configuration
REQ-015 With SDRAM_REF_TIMER_EN defined, the refresh timer SHALL count only while INIT_DONE_o=1 and SHALL reach terminal count every REFI_CYC cycles, free-running.
- At terminal count, REF_REQ_o SHALL be set and held until REF_ACK_i=1 is sampled.
- When terminal count and REF_ACK_i coincide, set SHALL win.
- A terminal count while REF_REQ_o is already 1 SHALL set REF_OVF_o until reset.
REQ-016 With SDRAM_REF_TIMER_EN undefined, the REF_REQ_o, REF_ACK_i and REF_OVF_o ports and the timer logic SHALL be absent.

Structure
REQ-017 A package sdram_pkg SHALL hold the command encodings and the FSM state enum.
REQ-018 One sub-module, sdram_cycle_timer (a loadable down-counter with a terminal-count pulse), SHALL serve both the WAIT and the T_* spacing timing, and a second instance SHALL serve the refresh interval.

Verification
REQ-019 WAIT_CYC=10, T_RP=2, T_RFC=4, REF_NUM=2, T_MRD=2 -> PRE at cycle 10, REF at 12 and 16, MRS at 20, INIT_DONE_o=1 at cycle 22, NOP in all other cycles.
REQ-020 Same setup -> ADDR_o=0x400 at cycle 10, ADDR_o=MODE_REG at cycle 20, ADDR_o=0 elsewhere; INIT_WAIT_200_o rises at cycle 10.
REQ-021 RST pulsed at cycle 17 -> next cycle all outputs at reset values; PRE reissued 10 cycles after the release.
REQ-022 SDRAM_REF_TIMER_EN with REFI_CYC=5 and ACK 1 cycle after each request -> REF_REQ_o every 5 cycles and REF_OVF_o stays 0.
REQ-023 SDRAM_REF_TIMER_EN with ACK withheld for 6 cycles -> REF_OVF_o=1 at the second terminal count and held.
REQ-024 REF_NUM=1 and T_*=1 -> back-to-back commands PRE, REF, MRS on consecutive cycles and INIT_DONE_o one cycle after MRS.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : SDRAM command encodings, init FSM state enum and a sizing helper
//            shared by the SDRAM init controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Commands as {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] c_cmd_nop = 4'b0111;
    localparam logic [3:0] c_cmd_pre = 4'b0010;
    localparam logic [3:0] c_cmd_ref = 4'b0001;
    localparam logic [3:0] c_cmd_mrs = 4'b0000;

    // Init FSM states; command states (PRE/REF/MRS) last exactly one cycle
    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_PRE  = 3'd1,
        ST_TRP  = 3'd2,
        ST_REF  = 3'd3,
        ST_TRFC = 3'd4,
        ST_MRS  = 3'd5,
        ST_TMRD = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    // Largest of four cycle counts, used to size the shared step timer
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_cycle_timer
// Brief    : Loadable down-counter. tc_o is high while the count is zero, so
//            loading N-1 gives a terminal count N cycles after the load edge.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority; otherwise count down to zero and hold there
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule : sdram_cycle_timer
`default_nettype wire

// File: rtl/sdram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_ctrl
// Brief    : SDRAM power-up initialisation sequencer:
//            WAIT -> PRE(all) -> REF x REF_NUM -> MRS -> DONE.
//            Optional macro SDRAM_REF_TIMER_EN adds a periodic refresh
//            request timer (REF_REQ_o / REF_ACK_i / REF_OVF_o).
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int                WAIT_CYC = 20000,
    parameter int                T_RP     = 3,
    parameter int                T_RFC    = 8,
    parameter int                T_MRD    = 2,
    parameter int                REF_NUM  = 8,
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] MODE_REG = 13'h032
`ifdef SDRAM_REF_TIMER_EN
    ,
    parameter int                REFI_CYC = 780
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              CKE_o,
    output logic [3:0]        CMD_o,
    output logic [ADDR_W-1:0] ADDR_o,
    output logic [1:0]        BA_o,
    output logic              INIT_WAIT_200_o,
    output logic              INIT_DONE_o
`ifdef SDRAM_REF_TIMER_EN
    ,
    output logic              REF_REQ_o,
    input  logic              REF_ACK_i,
    output logic              REF_OVF_o
`endif
);

    localparam int c_tmr_w = $clog2(max4(WAIT_CYC, T_RP, T_RFC, T_MRD) + 1);
    localparam int c_ref_w = $clog2(REF_NUM + 1);

    // Timer load values are N-1: the timer is zero in the last cycle of a span
    localparam logic [c_tmr_w-1:0] c_wait_ld = c_tmr_w'(WAIT_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_trp_ld  = c_tmr_w'(T_RP - 1);
    localparam logic [c_tmr_w-1:0] c_trfc_ld = c_tmr_w'(T_RFC - 1);
    localparam logic [c_tmr_w-1:0] c_tmrd_ld = c_tmr_w'(T_MRD - 1);
    localparam logic [c_ref_w-1:0] c_ref_num = c_ref_w'(REF_NUM);

    state_e              state_q, state_d;
    logic [c_ref_w-1:0]  ref_cnt_q, ref_cnt_d;
    logic                cke_q;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          ba_q;
    logic                init_wait_q;
    logic                init_done_q;

    logic                tmr_load;
    logic [c_tmr_w-1:0]  tmr_val;
    logic                tmr_tc;

    sdram_cycle_timer #(
        .WIDTH      (c_tmr_w)
    ) u_step_tmr (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (1'b1),
        .tc_o       (tmr_tc)
    );

    // Next state, timer reload on every command issue, refresh counting.
    // The first cycle out of reset (CKE still low) arms the power-up wait.
    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            ST_WAIT: begin
                if (!cke_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = c_wait_ld;
                end else if (tmr_tc) begin
                    state_d  = ST_PRE;
                    tmr_load = 1'b1;
                    tmr_val  = c_trp_ld;
                end
            end
            ST_PRE, ST_TRP: begin
                if (tmr_tc) begin
                    state_d   = ST_REF;
                    tmr_load  = 1'b1;
                    tmr_val   = c_trfc_ld;
                    ref_cnt_d = ref_cnt_q + 1'b1;
                end else begin
                    state_d = ST_TRP;
                end
            end
            ST_REF, ST_TRFC: begin
                if (tmr_tc) begin
                    if (ref_cnt_q == c_ref_num) begin
                        state_d  = ST_MRS;
                        tmr_load = 1'b1;
                        tmr_val  = c_tmrd_ld;
                    end else begin
                        state_d   = ST_REF;
                        tmr_load  = 1'b1;
                        tmr_val   = c_trfc_ld;
                        ref_cnt_d = ref_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_TRFC;
                end
            end
            ST_MRS, ST_TMRD: begin
                state_d = tmr_tc ? ST_DONE : ST_TMRD;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Command and address decoded from the next state so they register together
    always_comb begin
        cmd_d  = c_cmd_nop;
        addr_d = '0;
        case (state_d)
            ST_PRE: begin
                cmd_d      = c_cmd_pre;
                addr_d[10] = 1'b1;
            end
            ST_REF: begin
                cmd_d = c_cmd_ref;
            end
            ST_MRS: begin
                cmd_d  = c_cmd_mrs;
                addr_d = MODE_REG;
            end
            default: begin
                cmd_d  = c_cmd_nop;
                addr_d = '0;
            end
        endcase
    end

    // FSM state, counters and all registered pin outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_WAIT;
            ref_cnt_q   <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= c_cmd_nop;
            addr_q      <= '0;
            ba_q        <= 2'b00;
            init_wait_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            cke_q       <= 1'b1;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= 2'b00;
            init_wait_q <= init_wait_q | (state_d == ST_PRE);
            init_done_q <= (state_d == ST_DONE);
        end
    end

    assign CKE_o           = cke_q;
    assign CMD_o           = cmd_q;
    assign ADDR_o          = addr_q;
    assign BA_o            = ba_q;
    assign INIT_WAIT_200_o = init_wait_q;
    assign INIT_DONE_o     = init_done_q;

`ifdef SDRAM_REF_TIMER_EN
    localparam int                 c_refi_w  = $clog2(REFI_CYC + 1);
    localparam logic [c_refi_w-1:0] c_refi_ld = c_refi_w'(REFI_CYC - 1);

    logic refi_tc_raw;
    logic refi_tc;
    logic ref_req_q;
    logic ref_ovf_q;

    // Held at the reload value until init completes, then free-runs
    sdram_cycle_timer #(
        .WIDTH      (c_refi_w)
    ) u_refi_tmr (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (!init_done_q || refi_tc),
        .load_val_i (c_refi_ld),
        .en_i       (init_done_q),
        .tc_o       (refi_tc_raw)
    );

    assign refi_tc = init_done_q & refi_tc_raw;

    // Request set on terminal count (wins over ack); overflow if still pending
    always_ff @(posedge CLK) begin
        if (RST) begin
            ref_req_q <= 1'b0;
            ref_ovf_q <= 1'b0;
        end else begin
            if (refi_tc) begin
                ref_req_q <= 1'b1;
            end else if (REF_ACK_i) begin
                ref_req_q <= 1'b0;
            end
            if (refi_tc && ref_req_q) begin
                ref_ovf_q <= 1'b1;
            end
        end
    end

    assign REF_REQ_o = ref_req_q;
    assign REF_OVF_o = ref_ovf_q;
`endif

endmodule : sdram_init_ctrl
`default_nettype wire

// File: tb/tb_sdram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_init_ctrl
// Brief    : Directed self-checking bench for sdram_init_ctrl. Instance A uses
//            short timings (WAIT 10, tRP 2, tRFC 4, 2 refreshes, tMRD 2);
//            instance B uses all-minimum timings. Refresh-timer checks are
//            included when SDRAM_REF_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_init_ctrl;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  PRE  = 4'b0010;
    localparam logic [3:0]  REF  = 4'b0001;
    localparam logic [3:0]  MRS  = 4'b0000;
    localparam logic [12:0] MODE = 13'h032;

`ifdef SDRAM_REF_TIMER_EN
    localparam int LAST_A = 60;
`else
    localparam int LAST_A = 25;
`endif

    logic        clk;
    logic        rst;

    logic        a_cke, a_wait, a_done;
    logic [3:0]  a_cmd;
    logic [12:0] a_addr;
    logic [1:0]  a_ba;

    logic        b_cke, b_wait, b_done;
    logic [3:0]  b_cmd;
    logic [12:0] b_addr;
    logic [1:0]  b_ba;

`ifdef SDRAM_REF_TIMER_EN
    logic a_req, a_ack, a_ovf;
    logic b_req, b_ovf;
`endif

    int n_tests;
    int n_fail;

    sdram_init_ctrl #(
        .WAIT_CYC (10),
        .T_RP     (2),
        .T_RFC    (4),
        .T_MRD    (2),
        .REF_NUM  (2),
        .ADDR_W   (13),
        .MODE_REG (MODE)
`ifdef SDRAM_REF_TIMER_EN
        ,
        .REFI_CYC (5)
`endif
    ) u_dut_a (
        .CLK             (clk),
        .RST             (rst),
        .CKE_o           (a_cke),
        .CMD_o           (a_cmd),
        .ADDR_o          (a_addr),
        .BA_o            (a_ba),
        .INIT_WAIT_200_o (a_wait),
        .INIT_DONE_o     (a_done)
`ifdef SDRAM_REF_TIMER_EN
        ,
        .REF_REQ_o       (a_req),
        .REF_ACK_i       (a_ack),
        .REF_OVF_o       (a_ovf)
`endif
    );

    sdram_init_ctrl #(
        .WAIT_CYC (3),
        .T_RP     (1),
        .T_RFC    (1),
        .T_MRD    (1),
        .REF_NUM  (1),
        .ADDR_W   (13),
        .MODE_REG (MODE)
`ifdef SDRAM_REF_TIMER_EN
        ,
        .REFI_CYC (5)
`endif
    ) u_dut_b (
        .CLK             (clk),
        .RST             (rst),
        .CKE_o           (b_cke),
        .CMD_o           (b_cmd),
        .ADDR_o          (b_addr),
        .BA_o            (b_ba),
        .INIT_WAIT_200_o (b_wait),
        .INIT_DONE_o     (b_done)
`ifdef SDRAM_REF_TIMER_EN
        ,
        .REF_REQ_o       (b_req),
        .REF_ACK_i       (1'b0),
        .REF_OVF_o       (b_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed view {cke, cmd, addr, ba, init_wait, init_done}
    function automatic logic [31:0] pack(input logic cke, input logic [3:0] cmd,
                                         input logic [12:0] addr, input logic [1:0] ba,
                                         input logic w, input logic d);
        return {10'd0, cke, cmd, addr, ba, w, d};
    endfunction

    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    logic        e_req;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
`ifdef SDRAM_REF_TIMER_EN
        a_ack   = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset values
        chk("A reset", pack(a_cke, a_cmd, a_addr, a_ba, a_wait, a_done),
            pack(1'b0, NOP, 13'h0, 2'b00, 1'b0, 1'b0));
        chk("B reset", pack(b_cke, b_cmd, b_addr, b_ba, b_wait, b_done),
            pack(1'b0, NOP, 13'h0, 2'b00, 1'b0, 1'b0));
`ifdef SDRAM_REF_TIMER_EN
        chk("A reset req/ovf", {30'd0, a_req, a_ovf}, 32'd0);
`endif

        // Run 1: full init sequence; each loop iteration samples cycle c
        rst = 1'b0;
        for (int c = 0; c <= LAST_A; c++) begin
            @(negedge clk);
            e_cmd  = NOP;
            e_addr = 13'h0;
            if (c == 10) begin
                e_cmd  = PRE;
                e_addr = 13'h400;
            end else if (c == 12 || c == 16) begin
                e_cmd = REF;
            end else if (c == 20) begin
                e_cmd  = MRS;
                e_addr = MODE;
            end
            chk($sformatf("A cyc%0d", c), pack(a_cke, a_cmd, a_addr, a_ba, a_wait, a_done),
                pack(1'b1, e_cmd, e_addr, 2'b00, (c >= 10), (c >= 22)));

            if (c <= 8) begin
                e_cmd  = NOP;
                e_addr = 13'h0;
                if (c == 3) begin
                    e_cmd  = PRE;
                    e_addr = 13'h400;
                end else if (c == 4) begin
                    e_cmd = REF;
                end else if (c == 5) begin
                    e_cmd  = MRS;
                    e_addr = MODE;
                end
                chk($sformatf("B cyc%0d", c), pack(b_cke, b_cmd, b_addr, b_ba, b_wait, b_done),
                    pack(1'b1, e_cmd, e_addr, 2'b00, (c >= 3), (c >= 6)));
            end

`ifdef SDRAM_REF_TIMER_EN
            // Requests at 27, 32, 37, 42 acked one cycle later; request at 47 never acked
            e_req = (c >= 27) && ((((c - 27) % 5) < 2) || (c >= 47));
            chk($sformatf("A req cyc%0d", c), {31'd0, a_req}, {31'd0, e_req});
            chk($sformatf("A ovf cyc%0d", c), {31'd0, a_ovf}, {31'd0, (c >= 52)});
            a_ack = (c == 28) || (c == 33) || (c == 38) || (c == 43);
`endif
        end

        // Run 2: restart, abort with reset at cycle 17, then restart again
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
        end
        chk("A run2 cyc17", pack(a_cke, a_cmd, a_addr, a_ba, a_wait, a_done),
            pack(1'b1, NOP, 13'h0, 2'b00, 1'b1, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        chk("A abort reset", pack(a_cke, a_cmd, a_addr, a_ba, a_wait, a_done),
            pack(1'b0, NOP, 13'h0, 2'b00, 1'b0, 1'b0));
        rst = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            e_cmd  = (c == 10) ? PRE : ((c == 12) ? REF : NOP);
            e_addr = (c == 10) ? 13'h400 : 13'h0;
            chk($sformatf("A restart cyc%0d", c), pack(a_cke, a_cmd, a_addr, a_ba, a_wait, a_done),
                pack(1'b1, e_cmd, e_addr, 2'b00, (c >= 10), 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sdram_init_ctrl
`default_nettype wire
